// File: rtl/micro_pkg.sv
// Shared constants for the microcoded MIPS controller: opcodes, next-address
// select encodings and micro-state addresses.
package micro_pkg;

    typedef enum logic [1:0] {
        AC_FETCH = 2'd0,
        AC_DISP1 = 2'd1,
        AC_DISP2 = 2'd2,
        AC_SEQ   = 2'd3
    } addr_ctl_e;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_J     = 2;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_ADDI  = 8;
    localparam int unsigned OP_LW    = 35;
    localparam int unsigned OP_SW    = 43;

    localparam int unsigned US_FETCH   = 0;
    localparam int unsigned US_DECODE  = 1;
    localparam int unsigned US_MEMADDR = 2;
    localparam int unsigned US_MEMRD   = 3;
    localparam int unsigned US_MEMWB   = 4;
    localparam int unsigned US_MEMWR   = 5;
    localparam int unsigned US_REXEC   = 6;
    localparam int unsigned US_RWB     = 7;
    localparam int unsigned US_BEQ     = 8;
    localparam int unsigned US_JUMP    = 9;
    localparam int unsigned US_IEXEC   = 10;

endpackage

// File: rtl/micro_seq_if.sv
// Sequencer-side bundle between the IR / microcode ROM (master) and the
// micro-sequencer (slave).
interface micro_seq_if
    import micro_pkg::*;
#(
    parameter int unsigned UADDR_W = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned CNT_W   = 16
) ();

    logic [OP_W-1:0]    op;
    addr_ctl_e          addr_ctl;
    logic               stall;
    logic               trap_ack;
    logic [UADDR_W-1:0] upc;
    logic               illegal_op;
    logic               instr_start;
    logic [CNT_W-1:0]   instr_cnt;

    modport master (
        output op, addr_ctl, stall, trap_ack,
        input  upc, illegal_op, instr_start, instr_cnt
    );

    modport slave (
        input  op, addr_ctl, stall, trap_ack,
        output upc, illegal_op, instr_start, instr_cnt
    );

endinterface

// File: rtl/micro_dispatch_rom.sv
// Built-in dispatch tables: opcode to micro-address for DISP1 and DISP2.
// Purely combinational; misses steer to the trap address.
module micro_dispatch_rom
    import micro_pkg::*;
#(
    parameter int unsigned UADDR_W   = 4,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned TRAP_ADDR = 15
) (
    input  logic [OP_W-1:0]    op,
    output logic [UADDR_W-1:0] d1_addr,
    output logic               d1_miss,
    output logic [UADDR_W-1:0] d2_addr,
    output logic               d2_miss
);

    always_comb begin
        d1_addr = UADDR_W'(TRAP_ADDR);
        d1_miss = 1'b0;
        case (op)
            OP_W'(OP_RTYPE): d1_addr = UADDR_W'(US_REXEC);
            OP_W'(OP_LW):    d1_addr = UADDR_W'(US_MEMADDR);
            OP_W'(OP_SW):    d1_addr = UADDR_W'(US_MEMADDR);
            OP_W'(OP_BEQ):   d1_addr = UADDR_W'(US_BEQ);
            OP_W'(OP_J):     d1_addr = UADDR_W'(US_JUMP);
            OP_W'(OP_ADDI):  d1_addr = UADDR_W'(US_IEXEC);
            default:         d1_miss = 1'b1;
        endcase
    end

    always_comb begin
        d2_addr = UADDR_W'(TRAP_ADDR);
        d2_miss = 1'b0;
        case (op)
            OP_W'(OP_LW): d2_addr = UADDR_W'(US_MEMRD);
            OP_W'(OP_SW): d2_addr = UADDR_W'(US_MEMWR);
            default:      d2_miss = 1'b1;
        endcase
    end

endmodule

// File: rtl/micro_seq.sv
// Micro-PC sequencer: selects the next micro-address, parks in the trap state on
// undecoded opcodes until acknowledged, and counts retired instructions.
module micro_seq
    import micro_pkg::*;
#(
    parameter int unsigned UADDR_W   = 4,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TRAP_ADDR = 15
) (
    input logic        clk,
    input logic        rst_n,
    micro_seq_if.slave bus
);

    logic [UADDR_W-1:0] d1_addr, d2_addr;
    logic               d1_miss, d2_miss;

    logic [UADDR_W-1:0] upc_q;
    logic               illegal_q;
    logic               start_q;
    logic [CNT_W-1:0]   cnt_q;

    micro_dispatch_rom #(
        .UADDR_W   (UADDR_W),
        .OP_W      (OP_W),
        .TRAP_ADDR (TRAP_ADDR)
    ) u_rom (
        .op      (bus.op),
        .d1_addr (d1_addr),
        .d1_miss (d1_miss),
        .d2_addr (d2_addr),
        .d2_miss (d2_miss)
    );

    // Priority: stall, then trap hold/release, then the addr_ctl selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q     <= '0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (bus.stall) begin
            start_q <= 1'b0;
        end else if (upc_q == UADDR_W'(TRAP_ADDR)) begin
            if (bus.trap_ack) begin
                upc_q     <= '0;
                illegal_q <= 1'b0;
                start_q   <= 1'b1;
            end else begin
                start_q <= 1'b0;
            end
        end else begin
            start_q <= (bus.addr_ctl == AC_FETCH);
            unique case (bus.addr_ctl)
                AC_FETCH: begin
                    upc_q <= '0;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                AC_DISP1: begin
                    upc_q <= d1_addr;
                    if (d1_miss) illegal_q <= 1'b1;
                end
                AC_DISP2: begin
                    upc_q <= d2_addr;
                    if (d2_miss) illegal_q <= 1'b1;
                end
                AC_SEQ:   upc_q <= upc_q + UADDR_W'(1);
            endcase
        end
    end

    assign bus.upc         = upc_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_start = start_q;
    assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: drivers queue expected post-edge state,
// a monitor compares it one step after each rising edge.
module tb_micro_seq;
    import micro_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    micro_seq_if #(.UADDR_W(4), .OP_W(6), .CNT_W(16)) bus ();
    micro_seq_if #(.UADDR_W(4), .OP_W(6), .CNT_W(2))  bus2 ();

    micro_seq #(.UADDR_W(4), .OP_W(6), .CNT_W(16), .TRAP_ADDR(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    micro_seq #(.UADDR_W(4), .OP_W(6), .CNT_W(2), .TRAP_ADDR(15)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        bit    sel;
        int    upc;
        int    ill;
        int    st;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic check_state(input string nm, input bit sel, input int eu, input int ei,
                               input int es, input int ec);
        if (sel) begin
            check({nm, " upc"},   int'(bus2.upc), eu);
            check({nm, " ill"},   int'(bus2.illegal_op), ei);
            check({nm, " start"}, int'(bus2.instr_start), es);
            check({nm, " cnt"},   int'(bus2.instr_cnt), ec);
        end else begin
            check({nm, " upc"},   int'(bus.upc), eu);
            check({nm, " ill"},   int'(bus.illegal_op), ei);
            check({nm, " start"}, int'(bus.instr_start), es);
            check({nm, " cnt"},   int'(bus.instr_cnt), ec);
        end
    endtask

    // Monitor: compare the state produced by the edge after each queued stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_state(e.nm, e.sel, e.upc, e.ill, e.st, e.cnt);
        end
    end

    task automatic step(input int op, input addr_ctl_e ac, input bit st, input bit ack,
                        input int eu, input int ei, input int es, input int ec,
                        input string nm);
        exp_t e;
        @(negedge clk);
        bus.op       = 6'(op);
        bus.addr_ctl = ac;
        bus.stall    = st;
        bus.trap_ack = ack;
        e.sel = 1'b0; e.upc = eu; e.ill = ei; e.st = es; e.cnt = ec; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step_wrap(input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        bus.stall     = 1'b1;
        bus2.stall    = 1'b0;
        bus2.addr_ctl = AC_FETCH;
        e.sel = 1'b1; e.upc = 0; e.ill = 0; e.st = 1; e.cnt = ec; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.op = '0;  bus.addr_ctl = AC_SEQ;   bus.stall = 1'b1;  bus.trap_ack = 1'b0;
        bus2.op = '0; bus2.addr_ctl = AC_FETCH; bus2.stall = 1'b1; bus2.trap_ack = 1'b0;
        #12;
        check_state("reset", 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw
        step(35, AC_SEQ,   0, 0, 1, 0, 0, 0, "lw seq");
        step(35, AC_DISP1, 0, 0, 2, 0, 0, 0, "lw d1");
        step(35, AC_DISP2, 0, 0, 3, 0, 0, 0, "lw d2");
        step(35, AC_SEQ,   0, 0, 4, 0, 0, 0, "lw wb");
        step(35, AC_FETCH, 0, 0, 0, 0, 1, 1, "lw fetch");
        // sw
        step(43, AC_SEQ,   0, 0, 1, 0, 0, 1, "sw seq");
        step(43, AC_DISP1, 0, 0, 2, 0, 0, 1, "sw d1");
        step(43, AC_DISP2, 0, 0, 5, 0, 0, 1, "sw d2");
        step(43, AC_FETCH, 0, 0, 0, 0, 1, 2, "sw fetch");
        // beq
        step(4,  AC_SEQ,   0, 0, 1, 0, 0, 2, "beq seq");
        step(4,  AC_DISP1, 0, 0, 8, 0, 0, 2, "beq d1");
        step(4,  AC_FETCH, 0, 0, 0, 0, 1, 3, "beq fetch");
        // stall at upc 2 with DISP2 pending
        step(35, AC_SEQ,   0, 0, 1, 0, 0, 3, "stl seq");
        step(35, AC_DISP1, 0, 0, 2, 0, 0, 3, "stl d1");
        for (int i = 0; i < 4; i++) step(35, AC_DISP2, 1, 0, 2, 0, 0, 3, "stall hold");
        step(35, AC_DISP2, 0, 0, 3, 0, 0, 3, "stl d2");
        step(35, AC_FETCH, 0, 0, 0, 0, 1, 4, "stl fetch");
        step(35, AC_FETCH, 1, 0, 0, 0, 0, 4, "stall kills pulse");
        // illegal opcode via DISP1
        step(63, AC_SEQ,   0, 0, 1, 0, 0, 4, "ill seq");
        step(63, AC_DISP1, 0, 0, 15, 1, 0, 4, "ill d1");
        for (int i = 0; i < 3; i++)
            step(63, addr_ctl_e'(2'($urandom_range(0, 3))), 0, 0, 15, 1, 0, 4, "trap hold");
        step(63, AC_SEQ,   1, 1, 15, 1, 0, 4, "stall+ack");
        step(63, AC_SEQ,   0, 1, 0, 0, 1, 4, "trap ack");
        step(0,  AC_SEQ,   0, 1, 1, 0, 0, 4, "stray ack");
        step(0,  AC_DISP2, 0, 0, 15, 1, 0, 4, "d2 miss");
        step(0,  AC_FETCH, 0, 1, 0, 0, 1, 4, "d2 ack");
        // R-type, then async reset at upc 7
        step(0,  AC_SEQ,   0, 0, 1, 0, 0, 4, "r seq");
        step(0,  AC_DISP1, 0, 0, 6, 0, 0, 4, "r d1");
        step(0,  AC_SEQ,   0, 0, 7, 0, 0, 4, "r ex");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async rst", 1'b0, 0, 0, 0, 0);
        bus.stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        // async reset while trapped
        step(63, AC_SEQ,   0, 0, 1, 0, 0, 0, "tr seq");
        step(63, AC_DISP1, 0, 0, 15, 1, 0, 0, "tr d1");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("trap rst", 1'b0, 0, 0, 0, 0);
        bus.stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(63, AC_SEQ,   0, 0, 1, 0, 0, 0, "post rst");
        // j and addi
        step(2,  AC_DISP1, 0, 0, 9, 0, 0, 0, "j d1");
        step(2,  AC_FETCH, 0, 0, 0, 0, 1, 1, "j fetch");
        step(8,  AC_SEQ,   0, 0, 1, 0, 0, 1, "addi seq");
        step(8,  AC_DISP1, 0, 0, 10, 0, 0, 1, "addi d1");
        step(8,  AC_FETCH, 0, 0, 0, 0, 1, 2, "addi fetch");
        // 2-bit counter wrap
        step_wrap(1, "wrap1");
        step_wrap(2, "wrap2");
        step_wrap(3, "wrap3");
        step_wrap(0, "wrap4");
        step_wrap(1, "wrap5");

        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
